ct_ciu_l2csr_arb: RTL and testbench

//  Shares the single L2 CSR/L2-RAM read channel of the CIU among NUM_CORE cores. Buffers one

---
 rtl/ct_ciu_l2csr_pkg.sv | 26 ++
 rtl/ct_ciu_l2csr_rr_pick.sv | 34 +++
 rtl/ct_ciu_l2csr_arb.sv | 163 ++++++++++++++++
 tb/tb_ct_ciu_l2csr_arb.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_ciu_l2csr_pkg.sv
// Shared types and constants for the L2 CSR read-channel arbiter:
// FSM encoding, payload field map and bus widths.
package ct_ciu_l2csr_pkg;

   localparam int PLD_W   = 80;
   localparam int RDATA_W = 128;

   // payload field positions
   localparam int PLD_DCA_BIT = 79;
   localparam int PLD_REG_HI  = 75;
   localparam int PLD_REG_LO  = 68;
   localparam int PLD_RID_HI  = 31;
   localparam int PLD_RID_LO  = 28;
   localparam int PLD_WAY_HI  = 24;
   localparam int PLD_WAY_LO  = 21;
   localparam int PLD_IDX_HI  = 20;
   localparam int PLD_IDX_LO  = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_e;

endpackage

// File: rtl/ct_ciu_l2csr_rr_pick.sv
// Combinational round-robin picker: first pending core at or above rr_ptr, wrapping.
module ct_ciu_l2csr_rr_pick #(
   parameter int NUM_CORE = 4,
   parameter int PW       = 2
) (
   input  logic [NUM_CORE-1:0] pend_vld,
   input  logic [PW-1:0]       rr_ptr,
   output logic [NUM_CORE-1:0] gnt,
   output logic [PW-1:0]       gnt_idx,
   output logic                vld
);

   int          j;
   logic [PW-1:0] jj;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      vld     = 1'b0;
      j       = 0;
      jj      = '0;
      for (int k = 0; k < NUM_CORE; k++) begin
         j = int'(rr_ptr) + k;
         if (j >= NUM_CORE) j = j - NUM_CORE;
         jj = PW'(j);
         if (!vld && pend_vld[jj]) begin
            vld     = 1'b1;
            gnt[jj] = 1'b1;
            gnt_idx = jj;
         end
      end
   end

endmodule

// File: rtl/ct_ciu_l2csr_arb.sv
// Round-robin arbiter sharing the CIU L2 CSR read channel among NUM_CORE cores.
// Optional forced completion on WAIT timeout under macro CT_L2CSR_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no request in flight; grant next pending core if any
// ISSUE | one-cycle downstream sel pulse for the granted request
// WAIT  | waiting for downstream completion (or timeout if enabled)
// RESP  | one-cycle completion pulse and rdata back to granted core
module ct_ciu_l2csr_arb
   import ct_ciu_l2csr_pkg::*;
#(
   parameter int NUM_CORE    = 4,
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic                      forever_cpuclk,
   input  logic                      cpurst_b,
   input  logic [NUM_CORE-1:0]       ibiu_arb_csr_sel,
   input  logic [NUM_CORE*PLD_W-1:0] ibiu_arb_csr_wdata,
   output logic [NUM_CORE-1:0]       arb_ibiu_csr_cmplt,
   output logic [RDATA_W-1:0]        arb_ibiu_csr_rdata,
   output logic                      arb_ciu_csr_sel,
   output logic [PLD_W-1:0]          arb_ciu_csr_wdata,
   input  logic                      ciu_arb_csr_cmplt,
   input  logic [RDATA_W-1:0]        ciu_arb_csr_rdata,
   output logic                      arb_busy,
   output logic                      arb_proto_err,
   output logic                      arb_timeout
);

   localparam int PW = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1;

   arb_state_e          state_q, state_d;
   logic [NUM_CORE-1:0] pend_vld_q, pend_vld_d;
   logic [PLD_W-1:0]    pend_pld_q [NUM_CORE];
   logic [PLD_W-1:0]    pend_pld_d [NUM_CORE];
   logic [NUM_CORE-1:0] gnt_q, gnt_d;
   logic [PW-1:0]       gnt_idx_q, gnt_idx_d;
   logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [PLD_W-1:0]    wdata_q, wdata_d;
   logic [RDATA_W-1:0]  rdata_q, rdata_d;
   logic                proto_err_q, proto_err_d;

   logic [NUM_CORE-1:0] pick_gnt;
   logic [PW-1:0]       pick_idx;
   logic                pick_vld;
   logic [NUM_CORE-1:0] clr, pend_kept, cap;
   logic                spur;

`ifdef CT_L2CSR_TIMEOUT_EN
   localparam logic [9:0] TO_LIM = 10'(TIMEOUT_CYC);
   logic [9:0] to_cnt_q, to_cnt_d;
   logic       to_flag_q, to_flag_d;
`endif

   ct_ciu_l2csr_rr_pick #(.NUM_CORE(NUM_CORE), .PW(PW)) u_rr_pick (
      .pend_vld (pend_vld_q),
      .rr_ptr   (rr_ptr_q),
      .gnt      (pick_gnt),
      .gnt_idx  (pick_idx),
      .vld      (pick_vld)
   );

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      gnt_idx_d = gnt_idx_q;
      rr_ptr_d  = rr_ptr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      clr       = '0;
`ifdef CT_L2CSR_TIMEOUT_EN
      to_flag_d = 1'b0;
      to_cnt_d  = (state_q == ST_WAIT) ? to_cnt_q + 10'd1 : 10'd0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               gnt_d     = pick_gnt;
               gnt_idx_d = pick_idx;
               wdata_d   = pend_pld_q[pick_idx];
               state_d   = ST_ISSUE;
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (ciu_arb_csr_cmplt) begin
               rdata_d = ciu_arb_csr_rdata;
               state_d = ST_RESP;
            end
`ifdef CT_L2CSR_TIMEOUT_EN
            else if (to_cnt_q == TO_LIM) begin
               rdata_d   = '1;
               to_flag_d = 1'b1;
               state_d   = ST_RESP;
            end
`endif
         end
         ST_RESP: begin
            clr      = gnt_q;
            rr_ptr_d = (gnt_idx_q == PW'(NUM_CORE - 1)) ? '0 : gnt_idx_q + 1'b1;
            state_d  = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // the completing core's bit frees up this cycle, so a new sel for it is captured
      pend_kept  = pend_vld_q & ~clr;
      cap        = ibiu_arb_csr_sel & ~pend_kept;
      pend_vld_d = pend_kept | cap;
      for (int i = 0; i < NUM_CORE; i++) begin
         pend_pld_d[i] = cap[i] ? ibiu_arb_csr_wdata[i*PLD_W +: PLD_W] : pend_pld_q[i];
      end

      spur        = ciu_arb_csr_cmplt && (state_q != ST_WAIT);
      proto_err_d = spur | (|(ibiu_arb_csr_sel & pend_kept));
   end

   always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b) begin
         state_q     <= ST_IDLE;
         pend_vld_q  <= '0;
         gnt_q       <= '0;
         gnt_idx_q   <= '0;
         rr_ptr_q    <= '0;
         proto_err_q <= 1'b0;
`ifdef CT_L2CSR_TIMEOUT_EN
         to_cnt_q    <= '0;
         to_flag_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         pend_vld_q  <= pend_vld_d;
         gnt_q       <= gnt_d;
         gnt_idx_q   <= gnt_idx_d;
         rr_ptr_q    <= rr_ptr_d;
         proto_err_q <= proto_err_d;
`ifdef CT_L2CSR_TIMEOUT_EN
         to_cnt_q    <= to_cnt_d;
         to_flag_q   <= to_flag_d;
`endif
      end
   end

   always_ff @(posedge forever_cpuclk) begin
      pend_pld_q <= pend_pld_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
   end

   // data registers are not reset, so outputs are gated by state to read 0 when idle
   assign arb_ciu_csr_sel    = (state_q == ST_ISSUE);
   assign arb_ciu_csr_wdata  = (state_q != ST_IDLE) ? wdata_q : '0;
   assign arb_ibiu_csr_cmplt = (state_q == ST_RESP) ? gnt_q : '0;
   assign arb_ibiu_csr_rdata = (state_q == ST_RESP) ? rdata_q : '0;
   assign arb_busy           = (|pend_vld_q) | (state_q != ST_IDLE);
   assign arb_proto_err      = proto_err_q;
`ifdef CT_L2CSR_TIMEOUT_EN
   assign arb_timeout        = to_flag_q;
`else
   assign arb_timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_ct_ciu_l2csr_arb.sv
// Testbench for ct_ciu_l2csr_arb: directed scenarios plus randomized traffic
// against a transaction-level reference model. Covers CT_L2CSR_TIMEOUT_EN when defined.
module tb_ct_ciu_l2csr_arb;

   localparam int NC    = 4;
   localparam int TB_TO = 8;

   logic              clk = 1'b0;
   logic              rst_b;
   logic [NC-1:0]     sel;
   logic [NC*80-1:0]  wdata;
   logic [NC-1:0]     core_cmplt;
   logic [127:0]      core_rdata;
   logic              ciu_sel;
   logic [79:0]       ciu_wdata;
   logic              ciu_cmplt;
   logic [127:0]      ciu_rdata;
   logic              busy;
   logic              perr;
   logic              tmo;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc_cnt = 0;

   ct_ciu_l2csr_arb #(.NUM_CORE(NC), .TIMEOUT_CYC(TB_TO)) dut (
      .forever_cpuclk     (clk),
      .cpurst_b           (rst_b),
      .ibiu_arb_csr_sel   (sel),
      .ibiu_arb_csr_wdata (wdata),
      .arb_ibiu_csr_cmplt (core_cmplt),
      .arb_ibiu_csr_rdata (core_rdata),
      .arb_ciu_csr_sel    (ciu_sel),
      .arb_ciu_csr_wdata  (ciu_wdata),
      .ciu_arb_csr_cmplt  (ciu_cmplt),
      .ciu_arb_csr_rdata  (ciu_rdata),
      .arb_busy           (busy),
      .arb_proto_err      (perr),
      .arb_timeout        (tmo)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   function automatic logic [79:0] rnd80();
      return 80'({$urandom(), $urandom(), $urandom()});
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_b     = 1'b0;
      sel       = '0;
      wdata     = '0;
      ciu_cmplt = 1'b0;
      ciu_rdata = '0;
      repeat (2) adv();
      rst_b = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      n_tests++; if (ciu_sel !== 1'b0)     begin n_fail++; $display("FAIL reset_ciu_sel: got %b want 0", ciu_sel); end
      n_tests++; if (ciu_wdata !== '0)     begin n_fail++; $display("FAIL reset_ciu_wdata: got %h want 0", ciu_wdata); end
      n_tests++; if (core_cmplt !== '0)    begin n_fail++; $display("FAIL reset_core_cmplt: got %b want 0", core_cmplt); end
      n_tests++; if (core_rdata !== '0)    begin n_fail++; $display("FAIL reset_core_rdata: got %h want 0", core_rdata); end
      n_tests++; if (busy !== 1'b0)        begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
      n_tests++; if (perr !== 1'b0)        begin n_fail++; $display("FAIL reset_proto_err: got %b want 0", perr); end
      n_tests++; if (tmo !== 1'b0)         begin n_fail++; $display("FAIL reset_timeout: got %b want 0", tmo); end
   endtask

   task automatic test_single();
      logic [79:0] pld;
      pld = 80'h8000_0000_0000_0050_0012;
      do_reset();
      sel = 4'b0010;
      wdata[80 +: 80] = pld;
      adv(); sel = '0;
      n_tests++; if (ciu_sel !== 1'b0) begin n_fail++; $display("FAIL single_sel_early: got %b want 0", ciu_sel); end
      n_tests++; if (busy !== 1'b1)    begin n_fail++; $display("FAIL single_busy: got %b want 1", busy); end
      adv();
      n_tests++; if (ciu_sel !== 1'b1) begin n_fail++; $display("FAIL single_sel_t2: got %b want 1", ciu_sel); end
      n_tests++; if (ciu_wdata !== pld) begin n_fail++; $display("FAIL single_wdata: got %h want %h", ciu_wdata, pld); end
      repeat (3) begin
         adv();
         n_tests++;
         if (ciu_sel !== 1'b0 || core_cmplt !== '0) begin
            n_fail++; $display("FAIL single_wait_quiet: got sel=%b cmplt=%b want 0/0", ciu_sel, core_cmplt);
         end
      end
      n_tests++; if (ciu_wdata !== pld) begin n_fail++; $display("FAIL single_wdata_held: got %h want %h", ciu_wdata, pld); end
      adv();
      ciu_cmplt = 1'b1; ciu_rdata = 128'h1234;
      adv();
      ciu_cmplt = 1'b0; ciu_rdata = '0;
      n_tests++; if (core_cmplt !== 4'b0010)   begin n_fail++; $display("FAIL single_cmplt: got %b want 0010", core_cmplt); end
      n_tests++; if (core_rdata !== 128'h1234) begin n_fail++; $display("FAIL single_rdata: got %h want 1234", core_rdata); end
      adv();
      n_tests++; if (core_cmplt !== '0) begin n_fail++; $display("FAIL single_cmplt_pulse: got %b want 0", core_cmplt); end
      n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL single_idle_busy: got %b want 0", busy); end
   endtask

   task automatic test_multi();
      logic [79:0]  p [NC];
      logic [127:0] rd;
      int           order [4] = '{0, 2, 3, 0};
      int           last_sel = -100;
      int           w;
      bit           seen;
      do_reset();
      for (int i = 0; i < NC; i++) begin p[i] = rnd80(); wdata[i*80 +: 80] = p[i]; end
      sel = 4'b1101;
      adv(); sel = '0;
      for (int k = 0; k < 4; k++) begin
         if (k == 3) begin
            // after core 3 completes, rr wraps to 0: 0 must win over 3
            p[0] = rnd80(); p[3] = rnd80();
            wdata[0 +: 80] = p[0]; wdata[240 +: 80] = p[3];
            sel = 4'b1001; adv(); sel = '0;
         end
         seen = 0; w = 0;
         while (!seen && w < 20) begin
            if (ciu_sel === 1'b1) seen = 1;
            else begin adv(); w++; end
         end
         n_tests++; if (!seen) begin n_fail++; $display("FAIL multi_grant_%0d: got no ciu sel want sel within 20 cycles", k); end
         n_tests++;
         if (ciu_wdata !== p[order[k]]) begin
            n_fail++; $display("FAIL multi_order_%0d: got wdata %h want core%0d %h", k, ciu_wdata, order[k], p[order[k]]);
         end
         if (k > 0) begin
            n_tests++;
            if (cyc_cnt - last_sel < 4) begin
               n_fail++; $display("FAIL multi_spacing_%0d: got %0d cycles want >=4", k, cyc_cnt - last_sel);
            end
         end
         last_sel = cyc_cnt;
         rd = rnd128();
         repeat ($urandom_range(1, 3)) adv();
         ciu_cmplt = 1'b1; ciu_rdata = rd;
         adv();
         ciu_cmplt = 1'b0;
         n_tests++;
         if (core_cmplt !== (4'b0001 << order[k])) begin
            n_fail++; $display("FAIL multi_cmplt_%0d: got %b want %b", k, core_cmplt, 4'b0001 << order[k]);
         end
         n_tests++; if (core_rdata !== rd) begin n_fail++; $display("FAIL multi_rdata_%0d: got %h want %h", k, core_rdata, rd); end
         adv();
      end
   endtask

   task automatic test_dup();
      logic [79:0] p0, pa, pb, w2;
      int resp_at = -1;
      int n_sel = 0, c0 = 0, c2 = 0, other = 0;
      do_reset();
      p0 = rnd80(); pa = rnd80(); pb = ~pa;
      sel = 4'b0001; wdata[0 +: 80] = p0;
      adv(); sel = '0;
      adv();
      sel = 4'b0100; wdata[160 +: 80] = pa;
      adv();
      sel = 4'b0100; wdata[160 +: 80] = pb;
      adv(); sel = '0;
      n_tests++; if (perr !== 1'b1) begin n_fail++; $display("FAIL dup_proto_err: got %b want 1", perr); end
      ciu_cmplt = 1'b1; ciu_rdata = rnd128();
      adv(); ciu_cmplt = 1'b0;
      n_tests++; if (perr !== 1'b0) begin n_fail++; $display("FAIL dup_proto_err_pulse: got %b want 0", perr); end
      w2 = '0;
      for (int c = 0; c < 40; c++) begin
         if (ciu_sel === 1'b1) begin n_sel++; if (n_sel == 1) w2 = ciu_wdata; resp_at = c + 2; end
         if (core_cmplt === 4'b0001) c0++;
         else if (core_cmplt === 4'b0100) c2++;
         else if (core_cmplt !== '0) other++;
         ciu_cmplt = (c == resp_at);
         ciu_rdata = rnd128();
         adv();
      end
      ciu_cmplt = 1'b0;
      n_tests++; if (n_sel != 1)   begin n_fail++; $display("FAIL dup_sel_count: got %0d want 1", n_sel); end
      n_tests++; if (w2 !== pa)    begin n_fail++; $display("FAIL dup_payload: got %h want %h", w2, pa); end
      n_tests++; if (c0 != 1)      begin n_fail++; $display("FAIL dup_core0_cmplt: got %0d want 1", c0); end
      n_tests++; if (c2 != 1)      begin n_fail++; $display("FAIL dup_core2_cmplt: got %0d want 1", c2); end
      n_tests++; if (other != 0)   begin n_fail++; $display("FAIL dup_other_cmplt: got %0d want 0", other); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dup_busy: got %b want 0", busy); end
   endtask

   task automatic test_spurious();
      do_reset();
      ciu_cmplt = 1'b1; ciu_rdata = rnd128();
      adv(); ciu_cmplt = 1'b0;
      n_tests++; if (perr !== 1'b1)       begin n_fail++; $display("FAIL spur_proto_err: got %b want 1", perr); end
      n_tests++; if (core_cmplt !== '0)   begin n_fail++; $display("FAIL spur_core_cmplt: got %b want 0", core_cmplt); end
      n_tests++; if (busy !== 1'b0)       begin n_fail++; $display("FAIL spur_busy: got %b want 0", busy); end
      adv();
      n_tests++; if (perr !== 1'b0)       begin n_fail++; $display("FAIL spur_err_pulse: got %b want 0", perr); end
      n_tests++; if (ciu_sel !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL spur_stay_idle: got sel=%b busy=%b want 0/0", ciu_sel, busy);
      end
   endtask

   task automatic test_reset_mid();
      int bad = 0;
      do_reset();
      for (int i = 0; i < NC; i++) wdata[i*80 +: 80] = rnd80();
      sel = 4'b0111;
      adv(); sel = '0;
      adv();
      n_tests++; if (ciu_sel !== 1'b1) begin n_fail++; $display("FAIL rstmid_issue: got %b want 1", ciu_sel); end
      adv();
      rst_b = 1'b0;
      adv();
      n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
      n_tests++; if (ciu_wdata !== '0)   begin n_fail++; $display("FAIL rstmid_wdata: got %h want 0", ciu_wdata); end
      rst_b = 1'b1;
      ciu_cmplt = 1'b1; ciu_rdata = rnd128();
      adv(); ciu_cmplt = 1'b0;
      repeat (8) begin
         if (core_cmplt !== '0 || ciu_sel !== 1'b0 || busy !== 1'b0) bad++;
         adv();
      end
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", bad); end
   endtask

`ifdef CT_L2CSR_TIMEOUT_EN
   task automatic test_timeout();
      int bad = 0;
      do_reset();
      sel = 4'b0001; wdata[0 +: 80] = rnd80();
      adv(); sel = '0;
      adv();
      n_tests++; if (ciu_sel !== 1'b1) begin n_fail++; $display("FAIL to_issue: got %b want 1", ciu_sel); end
      for (int k = 1; k <= 9; k++) begin
         adv();
         if (core_cmplt !== '0 || tmo !== 1'b0) bad++;
      end
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL to_early: got %0d early cycles want 0", bad); end
      adv();
      n_tests++; if (core_cmplt !== 4'b0001) begin n_fail++; $display("FAIL to_cmplt: got %b want 0001", core_cmplt); end
      n_tests++; if (core_rdata !== '1)      begin n_fail++; $display("FAIL to_rdata: got %h want all-ones", core_rdata); end
      n_tests++; if (tmo !== 1'b1)           begin n_fail++; $display("FAIL to_flag: got %b want 1", tmo); end
      adv();
      ciu_cmplt = 1'b1;
      adv(); ciu_cmplt = 1'b0;
      n_tests++; if (perr !== 1'b1 || core_cmplt !== '0) begin
         n_fail++; $display("FAIL to_late_cmplt: got err=%b cmplt=%b want 1/0", perr, core_cmplt);
      end
   endtask
`endif

   task automatic test_random();
      bit           m_pend [NC];
      logic [79:0]  m_pld  [NC];
      int           m_rr = 0, m_core = 0, exp_issue = -1, exp_resp = -1, j;
      bit           m_free = 1, err_next = 0, exp_to = 0, in_wait, err, any, cin, found;
      logic [79:0]  exp_pld, r;
      logic [127:0] m_rdata;
      logic [NC-1:0] exp_cm;
      do_reset();
      for (int i = 0; i < NC; i++) begin m_pend[i] = 0; m_pld[i] = '0; end
      exp_pld = '0; m_rdata = '0;
      for (int c = 0; c < 3000; c++) begin
         any = 0;
         for (int i = 0; i < NC; i++) any |= m_pend[i];
         n_tests++;
         if (ciu_sel !== (c == exp_issue)) begin
            n_fail++; $display("FAIL rand_ciu_sel c%0d: got %b want %b", c, ciu_sel, c == exp_issue);
         end
         if (c == exp_issue) begin
            n_tests++; if (ciu_wdata !== exp_pld) begin n_fail++; $display("FAIL rand_wdata c%0d: got %h want %h", c, ciu_wdata, exp_pld); end
         end
         exp_cm = '0;
         if (c == exp_resp) exp_cm[m_core] = 1'b1;
         n_tests++; if (core_cmplt !== exp_cm) begin n_fail++; $display("FAIL rand_cmplt c%0d: got %b want %b", c, core_cmplt, exp_cm); end
         if (c == exp_resp) begin
            n_tests++; if (core_rdata !== m_rdata) begin n_fail++; $display("FAIL rand_rdata c%0d: got %h want %h", c, core_rdata, m_rdata); end
         end
         n_tests++; if (perr !== err_next) begin n_fail++; $display("FAIL rand_proto_err c%0d: got %b want %b", c, perr, err_next); end
         n_tests++; if (tmo !== (c == exp_resp && exp_to)) begin n_fail++; $display("FAIL rand_timeout c%0d: got %b want %b", c, tmo, c == exp_resp && exp_to); end
         n_tests++; if (busy !== (any || !m_free)) begin n_fail++; $display("FAIL rand_busy c%0d: got %b want %b", c, busy, any || !m_free); end

         for (int i = 0; i < NC; i++) begin
            sel[i] = ($urandom_range(0, 9) == 0);
            r = rnd80();
            wdata[i*80 +: 80] = r;
         end
         in_wait   = !m_free && (c > exp_issue) && (exp_resp < 0);
         cin       = in_wait ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 19) == 0);
         ciu_cmplt = cin;
         ciu_rdata = rnd128();

         err = cin && !in_wait;
         if (in_wait && cin) begin
            exp_resp = c + 1; m_rdata = ciu_rdata;
         end
`ifdef CT_L2CSR_TIMEOUT_EN
         else if (in_wait && (c - exp_issue - 1) == TB_TO) begin
            exp_resp = c + 1; m_rdata = '1; exp_to = 1;
         end
`endif
         if (m_free && any) begin
            found = 0;
            for (int k = 0; k < NC; k++) begin
               j = (m_rr + k) % NC;
               if (!found && m_pend[j]) begin found = 1; m_core = j; end
            end
            m_free = 0; exp_issue = c + 1; exp_resp = -1; exp_to = 0;
            exp_pld = m_pld[m_core];
         end
         if (c == exp_resp) begin
            m_pend[m_core] = 0; m_rr = (m_core + 1) % NC; m_free = 1;
         end
         for (int i = 0; i < NC; i++) begin
            if (sel[i]) begin
               if (m_pend[i]) err = 1;
               else begin m_pend[i] = 1; m_pld[i] = wdata[i*80 +: 80]; end
            end
         end
         err_next = err;
         adv();
      end
      sel = '0; ciu_cmplt = 1'b0;
   endtask

   initial begin
      rst_b = 1'b0; sel = '0; wdata = '0; ciu_cmplt = 1'b0; ciu_rdata = '0;
      test_reset();
      test_single();
      test_multi();
      test_dup();
      test_spurious();
      test_reset_mid();
`ifdef CT_L2CSR_TIMEOUT_EN
      test_timeout();
`endif
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish want finish before 2ms");
      $fatal(1, "watchdog expired");
   end

endmodule
